// File: rtl/temporizador_xadrez_if.sv
// Control and display bundle for the dual chess clock.
// The master drives the game controls and reads the clock state. The slave is
// the clock itself.
interface temporizador_xadrez_if #(
  parameter int N = 10
);
  // Control signals, all sampled on the rising clock edge:
  //   jogada is a single-cycle pulse with no ready/acknowledge. It is consumed
  //     in the cycle it is high, or dropped if it cannot apply (stopped, paused,
  //     flagged).
  //   inicia and zera_s are also sampled once per edge.
  //   pausa is a level.
  logic         zera_s;
  logic         inicia;
  logic         jogada;
  logic         pausa;
  logic [N-1:0] tempo_b;
  logic [N-1:0] tempo_p;
  logic         vez;
  logic         ativo;
  logic         fim_b;
  logic         fim_p;
  logic [1:0]   estado_dbg;

  modport master (
    output zera_s, inicia, jogada, pausa,
    input  tempo_b, tempo_p, vez, ativo, fim_b, fim_p, estado_dbg
  );

  modport slave (
    input  zera_s, inicia, jogada, pausa,
    output tempo_b, tempo_p, vez, ativo, fim_b, fim_p, estado_dbg
  );
endinterface

// File: rtl/temporizador_xadrez.sv
// Dual countdown chess clock with Fischer increment.
// A prescaler turns T clock cycles into one-second ticks. Each tick takes one
// second off the side to move. A move adds INC seconds to the mover (saturating
// at TMAX) and hands the turn over. The first side to reach zero is flagged,
// and the clock freezes until it is cleared.
module temporizador_xadrez #(
  parameter int T         = 50_000_000,
  parameter int N         = 10,
  parameter int TEMPO_INI = 600,
  parameter int INC       = 5,
  parameter int TMAX      = 999
) (
  input  logic                    clock,
  input  logic                    reset_n,
  temporizador_xadrez_if.slave    bus
);

  localparam int PW = (T > 1) ? $clog2(T) : 1;

  typedef enum logic [1:0] {PARADO, CONTA_B, CONTA_P, FIM} estado_t;

  estado_t       estado_q,  estado_d;
  logic [PW-1:0] presc_q,   presc_d;
  logic [N-1:0]  tempo_b_q, tempo_b_d;
  logic [N-1:0]  tempo_p_q, tempo_p_d;
  logic          vez_q,     vez_d;
  logic          ativo_q,   ativo_d;
  logic          fim_b_q,   fim_b_d;
  logic          fim_p_q,   fim_p_d;

  // The sum is one bit wider than the time register so that it cannot
  // overflow before it is clamped to TMAX.
  function automatic logic [N-1:0] soma_sat(input logic [N-1:0] t);
    logic [N:0] s;
    s = {1'b0, t} + (N+1)'(INC);
    if (s > (N+1)'(TMAX)) return N'(TMAX);
    else                  return s[N-1:0];
  endfunction

  // Next-state logic. Priority is zera_s > pausa > jogada > tick.
  always_comb begin
    estado_d  = estado_q;
    presc_d   = presc_q;
    tempo_b_d = tempo_b_q;
    tempo_p_d = tempo_p_q;
    vez_d     = vez_q;
    ativo_d   = ativo_q;
    fim_b_d   = fim_b_q;
    fim_p_d   = fim_p_q;

    if (bus.zera_s) begin
      estado_d  = PARADO;
      presc_d   = '0;
      tempo_b_d = N'(TEMPO_INI);
      tempo_p_d = N'(TEMPO_INI);
      vez_d     = 1'b0;
      ativo_d   = 1'b0;
      fim_b_d   = 1'b0;
      fim_p_d   = 1'b0;
    end else begin
      case (estado_q)
        PARADO: begin
          if (bus.inicia) begin
            estado_d = CONTA_B;
            presc_d  = '0;
            vez_d    = 1'b0;
            ativo_d  = 1'b1;
          end
        end
        CONTA_B, CONTA_P: begin
          if (bus.pausa) begin
            // Freeze: prescaler and times hold, and any move is discarded.
          end else if (bus.jogada) begin
            // A move takes precedence over a coinciding tick, so the mover is
            // not charged a second on the cycle it pressed.
            if (estado_q == CONTA_B) begin
              tempo_b_d = soma_sat(tempo_b_q);
              estado_d  = CONTA_P;
            end else begin
              tempo_p_d = soma_sat(tempo_p_q);
              estado_d  = CONTA_B;
            end
            vez_d   = ~vez_q;
            presc_d = '0;
          end else if (presc_q == PW'(T - 1)) begin
            presc_d = '0;
            if (estado_q == CONTA_B) begin
              tempo_b_d = tempo_b_q - N'(1);
              if (tempo_b_q == N'(1)) begin
                estado_d = FIM;
                fim_b_d  = 1'b1;
                ativo_d  = 1'b0;
              end
            end else begin
              tempo_p_d = tempo_p_q - N'(1);
              if (tempo_p_q == N'(1)) begin
                estado_d = FIM;
                fim_p_d  = 1'b1;
                ativo_d  = 1'b0;
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: begin
          // FIM: everything holds until a clear or a reset.
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q  <= PARADO;
      presc_q   <= '0;
      tempo_b_q <= N'(TEMPO_INI);
      tempo_p_q <= N'(TEMPO_INI);
      vez_q     <= 1'b0;
      ativo_q   <= 1'b0;
      fim_b_q   <= 1'b0;
      fim_p_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      presc_q   <= presc_d;
      tempo_b_q <= tempo_b_d;
      tempo_p_q <= tempo_p_d;
      vez_q     <= vez_d;
      ativo_q   <= ativo_d;
      fim_b_q   <= fim_b_d;
      fim_p_q   <= fim_p_d;
    end
  end

  assign bus.tempo_b    = tempo_b_q;
  assign bus.tempo_p    = tempo_p_q;
  assign bus.vez        = vez_q;
  assign bus.ativo      = ativo_q;
  assign bus.fim_b      = fim_b_q;
  assign bus.fim_p      = fim_p_q;
  assign bus.estado_dbg = estado_q;

endmodule

// File: tb/tb_temporizador_xadrez.sv
// Testbench for the dual chess clock. A behavioural model tracks each side's
// remaining seconds and the unpaused cycles elapsed in the current turn.
// Directed scenarios cover the documented timings, followed by a randomized
// run.
module tb_temporizador_xadrez;

  localparam int T         = 4;
  localparam int N         = 4;
  localparam int TEMPO_INI = 3;
  localparam int INC       = 2;
  localparam int TMAX      = 6;
  localparam int W         = 2 * N + 4;

  // clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  temporizador_xadrez_if #(.N(N)) bus ();

  temporizador_xadrez #(
    .T(T), .N(N), .TEMPO_INI(TEMPO_INI), .INC(INC), .TMAX(TMAX)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // reference model: 0 = stopped, 1 = running, 2 = flagged
  int m_mode, m_tb, m_tp, m_vez, m_fb, m_fp, m_elapsed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_push();
    logic [W-1:0] e;
    e = {N'(m_tb), N'(m_tp), 1'(m_vez), (m_mode == 1), 1'(m_fb), 1'(m_fp)};
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_mode = 0; m_tb = TEMPO_INI; m_tp = TEMPO_INI;
    m_vez = 0; m_fb = 0; m_fp = 0; m_elapsed = 0;
  endtask

  task automatic model_step(input bit z, input bit i, input bit j, input bit p);
    if (z) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (i) begin
        m_mode = 1; m_vez = 0; m_elapsed = 0;
      end
    end else if (m_mode == 1 && !p) begin
      if (j) begin
        if (m_vez == 0) m_tb = (m_tb + INC > TMAX) ? TMAX : m_tb + INC;
        else            m_tp = (m_tp + INC > TMAX) ? TMAX : m_tp + INC;
        m_vez = 1 - m_vez;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == T) begin
          m_elapsed = 0;
          if (m_vez == 0) begin
            m_tb--;
            if (m_tb == 0) begin m_mode = 2; m_fb = 1; end
          end else begin
            m_tp--;
            if (m_tp == 0) begin m_mode = 2; m_fp = 1; end
          end
        end
      end
    end
    model_push();
  endtask

  task automatic compare_all();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("tempo_b", 32'(bus.tempo_b), 32'(e[W-1 -: N]));
    chk("tempo_p", 32'(bus.tempo_p), 32'(e[W-1-N -: N]));
    chk("vez",     32'(bus.vez),     32'(e[3]));
    chk("ativo",   32'(bus.ativo),   32'(e[2]));
    chk("fim_b",   32'(bus.fim_b),   32'(e[1]));
    chk("fim_p",   32'(bus.fim_p),   32'(e[0]));
    chk("flags_excl", 32'(bus.fim_b & bus.fim_p), 32'd0);
  endtask

  // driver: apply inputs for one edge, then check just after it
  task automatic drive_cycle(input bit z, input bit i, input bit j, input bit p);
    bus.zera_s = z; bus.inicia = i; bus.jogada = j; bus.pausa = p;
    @(posedge clk);
    model_step(z, i, j, p);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.zera_s = 0; bus.inicia = 0; bus.jogada = 0; bus.pausa = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_push();
    compare_all();
    chk("reset_tempo_b", 32'(bus.tempo_b), 32'(TEMPO_INI));

    // 1: run white down to the flag
    drive_cycle(0, 1, 0, 0);                       // edge 0
    chk("start_ativo", 32'(bus.ativo), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      drive_cycle(0, 0, 0, 0);
      if (k == 3)  chk("e3_tempo_b", 32'(bus.tempo_b), 32'd3);
      if (k == 4)  chk("e4_tempo_b", 32'(bus.tempo_b), 32'd2);
      if (k == 8)  chk("e8_tempo_b", 32'(bus.tempo_b), 32'd1);
      if (k == 12) begin
        chk("e12_tempo_b", 32'(bus.tempo_b), 32'd0);
        chk("e12_fim_b",   32'(bus.fim_b),   32'd1);
        chk("e12_ativo",   32'(bus.ativo),   32'd0);
        chk("e12_tempo_p", 32'(bus.tempo_p), 32'd3);
      end
    end
    // flagged: inicia, jogada, pausa have no effect
    drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 0, 1, 0);
    drive_cycle(0, 0, 1, 1);
    idle(T + 1);
    chk("fim_hold_tempo_b", 32'(bus.tempo_b), 32'd0);
    chk("fim_hold_tempo_p", 32'(bus.tempo_p), 32'd3);
    drive_cycle(1, 0, 0, 0);
    chk("zera_tempo_b", 32'(bus.tempo_b), 32'd3);
    chk("zera_fim_b",   32'(bus.fim_b),   32'd0);

    // 2: moves and the new mover's tick timing
    drive_cycle(0, 1, 0, 0);                       // edge 0
    drive_cycle(0, 0, 0, 0);                       // edge 1
    drive_cycle(0, 0, 1, 0);                       // edge 2
    chk("mv1_tempo_b", 32'(bus.tempo_b), 32'd5);
    chk("mv1_vez",     32'(bus.vez),     32'd1);
    idle(3);                                       // edges 3..5
    chk("e5_tempo_p", 32'(bus.tempo_p), 32'd3);
    drive_cycle(0, 0, 0, 0);                       // edge 6
    chk("e6_tempo_p", 32'(bus.tempo_p), 32'd2);
    drive_cycle(0, 0, 1, 0);                       // edge 7
    chk("mv2_tempo_p", 32'(bus.tempo_p), 32'd4);
    chk("mv2_vez",     32'(bus.vez),     32'd0);

    // 3: rapid moves saturate at TMAX
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      drive_cycle(0, 0, 0, 0);
      drive_cycle(0, 0, 1, 0);
    end
    chk("sat_tempo_b", 32'(bus.tempo_b), 32'(TMAX));
    chk("sat_tempo_p", 32'(bus.tempo_p), 32'(TMAX));

    // 4a: a move on the tick cycle wins over the decrement
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 1, 0, 0);                       // edge 0
    idle(3);                                       // prescaler at T-1
    drive_cycle(0, 0, 1, 0);                       // edge 4
    chk("tick_mv_tempo_b", 32'(bus.tempo_b), 32'd5);
    chk("tick_mv_vez",     32'(bus.vez),     32'd1);

    // 4b: pause on cycles 2..11 delays the first tick to edge 14
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 1, 0, 0);                       // edge 0
    drive_cycle(0, 0, 0, 0);                       // edge 1
    for (int k = 2; k <= 11; k++) drive_cycle(0, 0, (k == 5), 1);
    chk("pause_vez", 32'(bus.vez), 32'd0);
    drive_cycle(0, 0, 0, 0);                       // edge 12
    drive_cycle(0, 0, 0, 0);                       // edge 13
    chk("e13_tempo_b", 32'(bus.tempo_b), 32'd3);
    drive_cycle(0, 0, 0, 0);                       // edge 14
    chk("e14_tempo_b", 32'(bus.tempo_b), 32'd2);

    // 5: asynchronous reset mid-count
    idle(5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    model_push();
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("async_rst_ativo", 32'(bus.ativo), 32'd0);

    // randomized run against the model
    for (int k = 0; k < 1500; k++) begin
      drive_cycle(($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 6) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
